// File: rtl/mem_copy_master.sv
// Word-copy initiator on the PicoRV32 native memory bus: reads len words from
// src and writes them to dst, one single-word read/write pair at a time.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | waiting for start; inputs sampled only here
// S_RD     | read request of the current source word on the bus
// S_RD_GAP | one idle bus cycle after the read handshake
// S_WR     | write request of the latched word to the destination
// S_WR_GAP | one idle bus cycle after the write; decide next word or finish
// S_FIN    | end of copy (normal or timed out); done pulses next cycle
module mem_copy_master #(
  parameter int ADDRWIDTH = 32,
  parameter int LENWIDTH  = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [ADDRWIDTH-1:0] src_addr,
  input  logic [ADDRWIDTH-1:0] dst_addr,
  input  logic [LENWIDTH-1:0]  len,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [LENWIDTH-1:0]  words_done,
  output logic                 mem_valid,
  output logic [ADDRWIDTH-1:0] mem_addr,
  output logic [31:0]          mem_wdata,
  output logic [3:0]           mem_wstrb,
  input  logic                 mem_ready,
  input  logic [31:0]          mem_rdata
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]        WAIT_LOAD  = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [ADDRWIDTH-1:0] ALIGN_MASK = ~ADDRWIDTH'(3);
  localparam logic [ADDRWIDTH-1:0] WORD_STEP  = ADDRWIDTH'(4);
  localparam bit                   TIMEOUT_EN = (TIMEOUT != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RD_GAP,
    S_WR,
    S_WR_GAP,
    S_FIN
  } state_t;

  state_t               state;
  logic [ADDRWIDTH-1:0] src_q;
  logic [ADDRWIDTH-1:0] dst_q;
  logic [LENWIDTH-1:0]  len_q;
  logic [CW-1:0]        wait_cnt;
  logic                 hs;
  logic                 timed_out;

  assign hs = mem_valid && mem_ready;
  // wait_cnt counts down the remaining stall cycles; zero means this is the last one allowed
  assign timed_out = TIMEOUT_EN && mem_valid && !mem_ready && (wait_cnt == '0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      wait_cnt   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      words_done <= '0;
      mem_valid  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= 4'h0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            src_q      <= src_addr & ALIGN_MASK;
            dst_q      <= dst_addr & ALIGN_MASK;
            len_q      <= len;
            words_done <= '0;
            error      <= 1'b0;
            busy       <= 1'b1;
            if (len == '0) begin
              state <= S_FIN;
            end else begin
              state     <= S_RD;
              mem_valid <= 1'b1;
              mem_addr  <= src_addr & ALIGN_MASK;
              mem_wstrb <= 4'h0;
              wait_cnt  <= WAIT_LOAD;
            end
          end
        end
        S_RD: begin
          if (hs) begin
            // mem_wdata doubles as the holding register for the word in flight
            mem_wdata <= mem_rdata;
            mem_valid <= 1'b0;
            state     <= S_RD_GAP;
          end else if (timed_out) begin
            mem_valid <= 1'b0;
            error     <= 1'b1;
            state     <= S_FIN;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        S_RD_GAP: begin
          mem_valid <= 1'b1;
          mem_addr  <= dst_q;
          mem_wstrb <= 4'hF;
          wait_cnt  <= WAIT_LOAD;
          state     <= S_WR;
        end
        S_WR: begin
          if (hs) begin
            words_done <= words_done + 1'b1;
            src_q      <= src_q + WORD_STEP;
            dst_q      <= dst_q + WORD_STEP;
            mem_valid  <= 1'b0;
            state      <= S_WR_GAP;
          end else if (timed_out) begin
            mem_valid <= 1'b0;
            error     <= 1'b1;
            state     <= S_FIN;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        S_WR_GAP: begin
          if (words_done == len_q) begin
            state <= S_FIN;
          end else begin
            mem_valid <= 1'b1;
            mem_addr  <= src_q;
            mem_wstrb <= 4'h0;
            wait_cnt  <= WAIT_LOAD;
            state     <= S_RD;
          end
        end
        S_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_master.sv
// Bench for mem_copy_master: a word-level copy model predicts the bus request
// sequence and end-of-copy status; a second instance covers the timeout path.
module tb_mem_copy_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, start;
  logic [31:0] src_addr, dst_addr;
  logic [15:0] len;
  logic        busy, done, error;
  logic [15:0] words_done;
  logic        mem_valid;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  logic        to_start;
  logic [31:0] to_src, to_dst;
  logic [15:0] to_len;
  logic        to_busy, to_done, to_error;
  logic [15:0] to_words;
  logic        to_valid;
  logic [31:0] to_addr, to_wdata;
  logic [3:0]  to_wstrb;
  logic        to_ready;
  logic [31:0] to_rdata;

  mem_copy_master #(.ADDRWIDTH(32), .LENWIDTH(16), .TIMEOUT(255)) dut (
    .clk(clk), .resetn(resetn), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .len(len), .busy(busy), .done(done), .error(error), .words_done(words_done),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  mem_copy_master #(.ADDRWIDTH(32), .LENWIDTH(16), .TIMEOUT(8)) dut_to (
    .clk(clk), .resetn(resetn), .start(to_start), .src_addr(to_src), .dst_addr(to_dst),
    .len(to_len), .busy(to_busy), .done(to_done), .error(to_error), .words_done(to_words),
    .mem_valid(to_valid), .mem_addr(to_addr), .mem_wdata(to_wdata), .mem_wstrb(to_wstrb),
    .mem_ready(to_ready), .mem_rdata(to_rdata)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } req_t;

  req_t        exp_q [$];
  logic [31:0] ram [logic [31:0]];
  int          wr_cnt [logic [31:0]];
  logic [31:0] wr_log [$];
  int          rd_wait = 0;
  int          wr_wait = 0;
  bit          idle_ready = 1'b0;
  bit          chk_en = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;
  int          n_done = 0;
  int          n_stall_wr = 0;
  logic        prev_done = 1'b0;
  logic [15:0] exp_words = '0;
  logic        exp_err = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Untouched memory returns a pattern derived from the address
  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return init_word(a);
  endfunction

  function automatic int writes_to(input logic [31:0] a);
    if (wr_cnt.exists(a)) return wr_cnt[a];
    return 0;
  endfunction

  // Responder: ready after rd_wait/wr_wait stall cycles, memory updated on the handshake
  initial begin : responder
    int wcnt;
    int lim;
    wcnt = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_rdata = $urandom;
      if (!mem_valid) begin
        wcnt = 0;
        mem_ready = idle_ready;
      end else begin
        lim = (mem_wstrb == 4'hF) ? wr_wait : rd_wait;
        if (wcnt >= lim) begin
          mem_ready = 1'b1;
          wcnt = 0;
          if (mem_wstrb == 4'hF) begin
            ram[mem_addr] = mem_wdata;
            wr_cnt[mem_addr] = writes_to(mem_addr) + 1;
            wr_log.push_back(mem_addr);
          end else begin
            mem_rdata = ram_rd(mem_addr);
          end
        end else begin
          mem_ready = 1'b0;
          wcnt++;
        end
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (mem_valid) begin
          chk("valid_implies_busy", 64'(busy), 64'd1);
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_request: addr %h wstrb %h while no request is due", mem_addr, mem_wstrb);
          end else begin
            chk("req_addr", 64'(mem_addr), 64'(exp_q[0].addr));
            chk("req_wstrb", 64'(mem_wstrb), 64'(exp_q[0].wstrb));
            if (exp_q[0].wstrb == 4'hF) chk("req_wdata", 64'(mem_wdata), 64'(exp_q[0].wdata));
            if (mem_wstrb == 4'hF && !mem_ready) n_stall_wr++;
            if (mem_ready) void'(exp_q.pop_front());
          end
        end
        if (done) begin
          n_done++;
          chk("done_width", 64'(prev_done), 64'd0);
          chk("done_words", 64'(words_done), 64'(exp_words));
          chk("done_error", 64'(error), 64'(exp_err));
          chk("done_busy", 64'(busy), 64'd0);
          chk("done_pending", 64'(exp_q.size()), 64'd0);
        end
        prev_done = done;
      end
    end
  end

  // Model: the whole copy expressed as the ordered list of bus requests it must produce
  task automatic launch(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    logic [31:0] mdl [logic [31:0]];
    req_t        r;
    logic [31:0] ra, wa, w;
    mdl = ram;
    exp_q.delete();
    for (int i = 0; i < int'(n); i++) begin
      ra = (s & ~32'h3) + 32'(4 * i);
      wa = (d & ~32'h3) + 32'(4 * i);
      w  = mdl.exists(ra) ? mdl[ra] : init_word(ra);
      mdl[wa] = w;
      r.addr = ra; r.wstrb = 4'h0; r.wdata = '0;
      exp_q.push_back(r);
      r.addr = wa; r.wstrb = 4'hF; r.wdata = w;
      exp_q.push_back(r);
    end
    exp_words = n;
    exp_err   = 1'b0;
    @(negedge clk);
    src_addr = s;
    dst_addr = d;
    len      = n;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: no done within %0d cycles", cyc);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_error"}, 64'(error), 64'd0);
    chk({tag, "_words"}, 64'(words_done), 64'd0);
    chk({tag, "_valid"}, 64'(mem_valid), 64'd0);
    chk({tag, "_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, "_wstrb"}, 64'(mem_wstrb), 64'd0);
  endtask

  initial begin : stim
    int cyc;
    int nv;
    resetn = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    to_start = 1'b0; to_src = '0; to_dst = '0; to_len = '0;
    to_ready = 1'b0; to_rdata = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    chk_rst("rst");
    chk("rst_to_valid", 64'(to_valid), 64'd0);
    chk("rst_to_error", 64'(to_error), 64'd0);
    chk("rst_to_busy", 64'(to_busy), 64'd0);
    resetn = 1'b1;
    chk_en = 1'b1;

    // len = 0: no bus activity, done two cycles after start
    launch(32'h0, 32'h0, 16'd0);
    wait_done(cyc);
    chk("len0_latency", 64'(cyc), 64'd2);
    @(negedge clk);
    chk("len0_done_count", 64'(n_done), 64'd1);

    // three words, one wait cycle on every request
    rd_wait = 1; wr_wait = 1;
    wr_log.delete();
    launch(32'h100, 32'h200, 16'd3);
    wait_done(cyc);
    chk("len3_latency", 64'(cyc), 64'd20);
    @(negedge clk);
    chk("len3_done_count", 64'(n_done), 64'd2);
    chk("len3_nwrites", 64'(wr_log.size()), 64'd3);
    chk("len3_wr0", 64'(wr_log[0]), 64'h200);
    chk("len3_wr2", 64'(wr_log[2]), 64'h208);
    chk("len3_mem204", 64'(ram_rd(32'h204)), 64'h0104_FEFB);
    chk("len3_mem208", 64'(ram_rd(32'h208)), 64'h0108_FEF7);

    // zero-wait responder asserting ready during idle cycles too
    rd_wait = 0; wr_wait = 0; idle_ready = 1'b1;
    launch(32'h180, 32'h280, 16'd2);
    wait_done(cyc);
    chk("zw_latency", 64'(cyc), 64'd10);
    chk("zw_mem284", 64'(ram_rd(32'h284)), 64'h0184_FE7B);
    idle_ready = 1'b0;
    @(negedge clk);

    // write stalled for 10 cycles
    wr_wait = 10;
    n_stall_wr = 0;
    launch(32'h400, 32'h500, 16'd1);
    wait_done(cyc);
    chk("stall_latency", 64'(cyc), 64'd16);
    chk("stall_cycles", 64'(n_stall_wr), 64'd10);
    chk("stall_single_write", 64'(writes_to(32'h500)), 64'd1);
    chk("stall_mem500", 64'(ram_rd(32'h500)), 64'h0400_FBFF);

    // unaligned source, destination wrapping past the top of memory, start ignored while busy
    wr_wait = 0;
    wr_log.delete();
    launch(32'h103, 32'hFFFF_FFFC, 16'd2);
    repeat (2) @(negedge clk);
    src_addr = 32'h900; dst_addr = 32'hA00; len = 16'd5; start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    chk("wrap_nwrites", 64'(wr_log.size()), 64'd2);
    chk("wrap_wr0", 64'(wr_log[0]), 64'hFFFF_FFFC);
    chk("wrap_wr1", 64'(wr_log[1]), 64'h0);
    chk("wrap_memtop", 64'(ram_rd(32'hFFFF_FFFC)), 64'h0100_FEFF);
    chk("wrap_mem0", 64'(ram_rd(32'h0)), 64'h0104_FEFB);
    repeat (5) @(negedge clk);
    chk("wrap_idle_after", 64'(busy), 64'd0);

    // reset during the write of word 2
    wr_wait = 3;
    launch(32'h600, 32'h700, 16'd3);
    nv = 0;
    while (!(mem_valid && mem_wstrb == 4'hF && words_done == 16'd1) && nv < 100) begin
      @(negedge clk);
      nv++;
    end
    chk("rstmid_reached_wr2", 64'(nv < 100), 64'd1);
    resetn = 1'b0;
    @(negedge clk);
    chk_rst("rstmid");
    exp_q.delete();
    resetn = 1'b1;
    wr_wait = 0;
    launch(32'h0, 32'h300, 16'd1);
    wait_done(cyc);
    chk("after_rst_latency", 64'(cyc), 64'd6);
    chk("after_rst_mem300", 64'(ram_rd(32'h300)), 64'h0104_FEFB);
    chk("rstmid_no_word2", 64'(writes_to(32'h704)), 64'd0);

    // timeout instance: responder never ready
    @(negedge clk);
    to_src = 32'h40; to_dst = 32'h80; to_len = 16'd2; to_start = 1'b1;
    @(negedge clk);
    to_start = 1'b0;
    cyc = 1; nv = 0;
    while (!to_done && cyc < 100) begin
      if (to_valid) begin
        nv++;
        chk("to_addr", 64'(to_addr), 64'h40);
        chk("to_wstrb", 64'(to_wstrb), 64'd0);
        chk("to_wdata", 64'(to_wdata), 64'd0);
      end
      @(negedge clk);
      cyc++;
    end
    chk("to_valid_cycles", 64'(nv), 64'd8);
    chk("to_done_latency", 64'(cyc), 64'd10);
    chk("to_error", 64'(to_error), 64'd1);
    chk("to_words", 64'(to_words), 64'd0);
    chk("to_busy_at_done", 64'(to_busy), 64'd0);
    @(negedge clk);
    to_start = 1'b1;
    @(negedge clk);
    to_start = 1'b0;
    chk("to_error_cleared", 64'(to_error), 64'd0);
    chk("to_busy_restart", 64'(to_busy), 64'd1);
    cyc = 1;
    while (!to_done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("to_second_done_latency", 64'(cyc), 64'd10);
    chk("to_second_error", 64'(to_error), 64'd1);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

endmodule
